// File: rtl/phy_reg_free_list_if.sv
// ---------------------------------------------------------------------------
// phy_reg_free_list_if
// Bundles the allocation (rename/dispatch) and release (commit) signals of the
// physical-register free list.
//   master : rename/commit side -- drives requests and releases, reads tags,
//            alloc_ok, free_count and overflow_err.
//   slave  : the free list itself.
// Parameters:
//   PHY_REG_SEL : physical tag width
//   FL_SEL      : log2 of free-list capacity (free_count is FL_SEL+1 bits)
// ---------------------------------------------------------------------------
interface phy_reg_free_list_if #(
    parameter int PHY_REG_SEL = 6,
    parameter int FL_SEL      = 5
);
    // allocation side
    logic                   alloc_req_1;
    logic                   alloc_req_2;
    logic                   stall_DP;
    logic                   prmiss;
    logic [PHY_REG_SEL-1:0] alloc_tag_1;
    logic [PHY_REG_SEL-1:0] alloc_tag_2;
    logic                   alloc_ok;
    // release side
    logic                   commit_valid1;
    logic                   commit_valid2;
    logic [4:0]             commit_dst_1;
    logic [4:0]             commit_dst_2;
    logic [PHY_REG_SEL-1:0] commit_release_tag_1;
    logic [PHY_REG_SEL-1:0] commit_release_tag_2;
    // status
    logic [FL_SEL:0]        free_count;
    logic                   overflow_err;

    modport master (
        output alloc_req_1, alloc_req_2, stall_DP, prmiss,
        output commit_valid1, commit_valid2, commit_dst_1, commit_dst_2,
        output commit_release_tag_1, commit_release_tag_2,
        input  alloc_tag_1, alloc_tag_2, alloc_ok, free_count, overflow_err
    );

    modport slave (
        input  alloc_req_1, alloc_req_2, stall_DP, prmiss,
        input  commit_valid1, commit_valid2, commit_dst_1, commit_dst_2,
        input  commit_release_tag_1, commit_release_tag_2,
        output alloc_tag_1, alloc_tag_2, alloc_ok, free_count, overflow_err
    );
endinterface

// File: rtl/phy_reg_free_list.sv
// ---------------------------------------------------------------------------
// phy_reg_free_list
// Two-wide circular FIFO of free physical register tags. Rename pops up to two
// tags per cycle (combinational read at head); commit pushes up to two released
// tags per cycle (compacted at tail). Releases become visible the next cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset (reloads tags ARCH_REG_NUM..PHY_REG_NUM-1)
//   fl_if  : slave side of phy_reg_free_list_if (requests, releases, tags,
//            alloc_ok, free_count, sticky overflow_err)
// ---------------------------------------------------------------------------
module phy_reg_free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int PHY_REG_SEL  = 6,
    parameter int ARCH_REG_NUM = 32,
    parameter int FL_NUM       = PHY_REG_NUM - ARCH_REG_NUM,
    parameter int FL_SEL       = 5
) (
    input  logic               clk,
    input  logic               reset,
    phy_reg_free_list_if.slave fl_if
);

    localparam logic [FL_SEL:0] FL_NUM_W = (FL_SEL+1)'(FL_NUM);

    logic [PHY_REG_SEL-1:0] fl_r [FL_NUM];
    logic [FL_SEL-1:0]      head_r;
    logic [FL_SEL-1:0]      tail_r;
    logic [FL_SEL:0]        count_r;
    logic                   overflow_r;

    logic [1:0]             reqnum_s;
    logic                   alloc_ok_s;
    logic [1:0]             pop_n_s;
    logic                   rel_1_s;
    logic                   rel_2_s;
    logic [1:0]             push_n_s;
    logic [1:0]             push_ok_n_s;
    logic                   over_s;
    logic [FL_SEL:0]        avail_s;
    logic [FL_SEL:0]        room_s;
    logic [FL_SEL:0]        count_next_s;
    logic [PHY_REG_SEL-1:0] wr_tag_a_s;
    logic [PHY_REG_SEL-1:0] wr_tag_b_s;
    logic [FL_SEL-1:0]      head_p1_s;
    logic [FL_SEL-1:0]      tail_p1_s;

    // Pointer advance with modulo-FL_NUM wrap (capacity need not be a power of two).
    function automatic logic [FL_SEL-1:0] ptr_add(input logic [FL_SEL-1:0] ptr,
                                                   input logic [1:0]        inc);
        logic [FL_SEL:0] sum;
        logic [FL_SEL:0] wrapped;
        sum = {1'b0, ptr} + {{(FL_SEL-1){1'b0}}, inc};
        if (sum >= FL_NUM_W) begin
            wrapped = sum - FL_NUM_W;
        end else begin
            wrapped = sum;
        end
        return wrapped[FL_SEL-1:0];
    endfunction

    // Request decode, pop/push sizing and overflow clipping.
    always_comb begin
        reqnum_s = 2'd0;
        if (fl_if.alloc_req_1 && fl_if.alloc_req_2) begin
            reqnum_s = 2'd2;
        end else if (fl_if.alloc_req_1) begin
            reqnum_s = 2'd1;
        end else begin
            reqnum_s = 2'd0;
        end

        alloc_ok_s = (count_r >= {{(FL_SEL-1){1'b0}}, reqnum_s});

        if (!fl_if.stall_DP && !fl_if.prmiss && alloc_ok_s) begin
            pop_n_s = reqnum_s;
        end else begin
            pop_n_s = 2'd0;
        end

        rel_1_s  = fl_if.commit_valid1 && (fl_if.commit_dst_1 != 5'd0);
        rel_2_s  = fl_if.commit_valid2 && (fl_if.commit_dst_2 != 5'd0);
        push_n_s = {1'b0, rel_1_s} + {1'b0, rel_2_s};

        // Slot 1 always lands first; a lone slot-2 release is compacted down to tail.
        if (rel_1_s) begin
            wr_tag_a_s = fl_if.commit_release_tag_1;
        end else begin
            wr_tag_a_s = fl_if.commit_release_tag_2;
        end
        wr_tag_b_s = fl_if.commit_release_tag_2;

        // Space left after this cycle's pop; pushes beyond it are dropped.
        avail_s = count_r - {{(FL_SEL-1){1'b0}}, pop_n_s};
        room_s  = FL_NUM_W - avail_s;
        if ({{(FL_SEL-1){1'b0}}, push_n_s} > room_s) begin
            push_ok_n_s = room_s[1:0];
            over_s      = 1'b1;
        end else begin
            push_ok_n_s = push_n_s;
            over_s      = 1'b0;
        end

        count_next_s = avail_s + {{(FL_SEL-1){1'b0}}, push_ok_n_s};
        head_p1_s    = ptr_add(head_r, 2'd1);
        tail_p1_s    = ptr_add(tail_r, 2'd1);
    end

    // Free-list storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FL_NUM; i++) begin
                fl_r[i] <= PHY_REG_SEL'(ARCH_REG_NUM + i);
            end
            head_r     <= {FL_SEL{1'b0}};
            tail_r     <= {FL_SEL{1'b0}};
            count_r    <= FL_NUM_W;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_n_s != 2'd0) begin
                fl_r[tail_r] <= wr_tag_a_s;
            end
            if (push_ok_n_s == 2'd2) begin
                fl_r[tail_p1_s] <= wr_tag_b_s;
            end
            head_r     <= ptr_add(head_r, pop_n_s);
            tail_r     <= ptr_add(tail_r, push_ok_n_s);
            count_r    <= count_next_s;
            overflow_r <= overflow_r | over_s;
        end
    end

    assign fl_if.alloc_tag_1  = fl_r[head_r];
    assign fl_if.alloc_tag_2  = fl_r[head_p1_s];
    assign fl_if.alloc_ok     = alloc_ok_s;
    assign fl_if.free_count   = count_r;
    assign fl_if.overflow_err = overflow_r;

endmodule

// File: doc/phy_reg_free_list.md
Name: phy_reg_free_list

Overview:
- Physical-register free list.
- The rename/dispatch stage draws up to two free physical tags per cycle from it.
- The commit stage returns up to two released tags per cycle. These are the original mappings freed by the ROB commit port.
- Implemented as a 2-wide circular FIFO; it closes the loop on the ROB's commit_release_tag outputs.

Parameters:
- PHY_REG_NUM, 64, total physical registers.
- PHY_REG_SEL, 6, tag width, log2(PHY_REG_NUM).
- ARCH_REG_NUM, 32, architectural registers; p0..p31 are mapped at reset.
- FL_NUM, PHY_REG_NUM-ARCH_REG_NUM (32), free-list capacity.
- FL_SEL, 5, log2(FL_NUM).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous reset, active-low: reset==0 at posedge resets the block.
- alloc_req_1  input  1  rename slot 1 needs a destination tag.
- alloc_req_2  input  1  rename slot 2 needs a destination tag; legal only with alloc_req_1.
- stall_DP  input  1  dispatch stalled; no allocation is consumed.
- prmiss  input  1  branch mispredict; allocation is suppressed this cycle.
- alloc_tag_1  output  PHY_REG_SEL  tag for slot 1.
- alloc_tag_2  output  PHY_REG_SEL  tag for slot 2.
- alloc_ok  output  1  enough free tags exist for the current request.
- commit_valid1  input  1  commit slot 1 valid.
- commit_valid2  input  1  commit slot 2 valid.
- commit_dst_1  input  5  architectural destination of commit slot 1; 0 means no destination.
- commit_dst_2  input  5  architectural destination of commit slot 2.
- commit_release_tag_1  input  PHY_REG_SEL  tag freed by commit slot 1.
- commit_release_tag_2  input  PHY_REG_SEL  tag freed by commit slot 2.
- free_count  output  FL_SEL+1  number of free tags currently held.
- overflow_err  output  1  sticky error flag: a push was attempted while full.

Behaviour:
- Storage: fl[FL_NUM] of PHY_REG_SEL bits; head (pop pointer) and tail (push pointer), both FL_SEL bits, incrementing with modulo FL_NUM wrap; count is FL_SEL+1 bits.
- Reset (reset==0 at posedge), required state:
  - fl[i] = ARCH_REG_NUM+i;
  - head = 0, tail = 0;
  - count = FL_NUM, so free_count = 32;
  - overflow_err = 0.
  - Reset overrides every other input in the same cycle, including a reset asserted mid-burst.
- Request count: reqnum = 2 if alloc_req_1 & alloc_req_2, 1 if only alloc_req_1, else 0.
- Read side is combinational:
  - alloc_tag_1 = fl[head];
  - alloc_tag_2 = fl[head+1 mod FL_NUM];
  - alloc_ok = (count >= reqnum).
  - Tags released in the current cycle are NOT visible until the next cycle; there is no bypass.
- Pop:
  - pop_n = reqnum when ~stall_DP & ~prmiss & alloc_ok, else 0.
  - head advances by pop_n.
  - With alloc_ok=0 nothing is popped, and dispatch must stall.
- Push:
  - rel_1 = commit_valid1 & (commit_dst_1 != 0).
  - rel_2 = commit_valid2 & (commit_dst_2 != 0).
  - Write order is slot 1 then slot 2, compacted:
    - if only rel_2 is set, tag_2 goes to fl[tail];
    - if both are set, tag_1 goes to fl[tail] and tag_2 to fl[tail+1].
  - tail advances by push_n = rel_1 + rel_2.
- Simultaneous push and pop:
  - count_next = count - pop_n + push_n, computed in FL_SEL+1 bits.
  - A push into slots freed by a same-cycle pop is legal.
  - Full check: count - pop_n + push_n > FL_NUM sets overflow_err=1 (sticky until reset). The excess writes are dropped and count saturates at FL_NUM.
- Empty boundary:
  - count=0: alloc_ok = (reqnum==0).
  - count=1 with reqnum=2: alloc_ok=0 and nothing is popped; the single tag stays available.
- Wrap: head/tail at FL_NUM-1 with an advance of 2 land on 1; tag_2 reads fl[0].
- prmiss: suppresses pop only; commits in the same cycle still push. Free-list rollback of squashed allocations is out of scope for this block.
- Latency: allocation is same-cycle combinational; a release becomes allocatable 1 cycle after commit.

Test Plan:
- Reset then alloc_req_1=alloc_req_2=1, no stall for 1 cycle:
  - alloc_tag_1=32, alloc_tag_2=33, alloc_ok=1;
  - next cycle free_count=30, alloc_tag_1=34.
- Drain: 16 double allocations bring free_count to 0.
  - Then alloc_req_1=1 gives alloc_ok=0, and head does not move.
  - Then commit_valid1=1, commit_dst_1=5, tag=40; next cycle alloc_ok=1 and alloc_tag_1=40.
- Compaction: commit_valid1=1 with commit_dst_1=0 (tag 7), plus commit_valid2=1, dst=3, tag=9 -> only 9 is pushed; free_count increases by 1.
- Wrap: after 31 single pops and 31 releases, head=31; a double allocation returns fl[31] and fl[0], then head=1.
- Simultaneous events:
  - free_count=1, reqnum=1, plus two releases in the same cycle -> free_count=2 next cycle;
  - prmiss=1 in the same cycle -> free_count=3 and no pop.
- Overflow: at full (count=32), release 1 tag -> overflow_err=1, free_count stays 32.
  - Then assert reset=0 for 1 cycle -> overflow_err=0, free_count=32, alloc_tag_1=32.
